// File: rtl/risc16f_mem_arbiter.sv
// Purpose : shares one single-port synchronous RAM between the risc16f fetch port
//           (read-only) and data port (read/write); decodes the LED register pair.
// Latency : grant in cycle t, valid in t+1; one access per two cycles at best.
// Backpr. : requesters hold req until their valid; reqs are ignored in RESP, and
//           data wins ties unless fetch has waited DATA_STREAK data grants.
// Ports   : clk/rst            - clock, synchronous active-high reset
//           i_req/i_addr       - fetch request and byte address
//           i_valid/i_rdata    - fetch completion pulse and word (0 when idle)
//           d_req/d_we/d_addr/d_wdata - data request, direction, byte address, write data
//           d_valid/d_rdata    - data completion pulse and read word (0 when idle)
//           m_en/m_we/m_addr/m_wdata/m_rdata - RAM port (word address)
//           led                - {led_2, led_1, led_0}
module risc16f_mem_arbiter #(
    parameter int unsigned DATA_STREAK = 3,
    parameter logic [15:0] LED_BASE    = 16'h0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_valid,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [14:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    output logic [23:0] led
);

    localparam logic [15:0] LED_HI     = LED_BASE + 16'd2;
    localparam logic [3:0]  STREAK_MAX = 4'(DATA_STREAK);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  streak;
    logic [7:0]  led_0;
    logic [7:0]  led_1;
    logic [7:0]  led_2;

    // Transaction attributes latched on grant, consumed in RESP.
    logic        i_vld_q;
    logic        d_vld_q;
    logic        d_led_q;
    logic        d_we_q;
    logic [15:0] led_rd_q;

    logic        in_idle;
    logic        d_led_lo;
    logic        d_led_hi;
    logic        d_led;
    logic        grant_d;
    logic        grant_i;
    logic        unused_addr_lsb;

    // Byte addresses alias onto words, so bit0 never takes part in decoding.
    assign unused_addr_lsb = i_addr[0] ^ d_addr[0];

    always_comb begin
        in_idle  = (state == IDLE);
        d_led_lo = (d_addr[15:1] == LED_BASE[15:1]);
        d_led_hi = (d_addr[15:1] == LED_HI[15:1]);
        d_led    = d_led_lo | d_led_hi;
        // Data has priority unless fetch has been passed over STREAK_MAX times in a row.
        grant_d  = in_idle && d_req && (!i_req || (streak != STREAK_MAX));
        grant_i  = in_idle && i_req && !grant_d;
        // LED-register accesses never touch RAM; fetch is never LED-decoded.
        m_en     = !rst && (grant_i || (grant_d && !d_led));
        m_we     = !rst && grant_d && !d_led && d_we;
        m_addr   = grant_d ? d_addr[15:1] : i_addr[15:1];
        m_wdata  = d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            streak   <= 4'd0;
            led_0    <= 8'h00;
            led_1    <= 8'h00;
            led_2    <= 8'h00;
            i_vld_q  <= 1'b0;
            d_vld_q  <= 1'b0;
            d_led_q  <= 1'b0;
            d_we_q   <= 1'b0;
            led_rd_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    i_vld_q  <= grant_i;
                    d_vld_q  <= grant_d;
                    d_led_q  <= d_led;
                    d_we_q   <= d_we;
                    // LED read value is captured before this cycle's LED write lands.
                    led_rd_q <= d_led_hi ? {8'h00, led_2} : {led_1, led_0};
                    if (grant_i || grant_d) begin
                        state <= RESP;
                    end
                    if (grant_i || !i_req) begin
                        streak <= 4'd0;
                    end else if (grant_d && (streak != STREAK_MAX)) begin
                        streak <= streak + 4'd1;
                    end
                    if (grant_d && d_we && d_led_lo) begin
                        {led_1, led_0} <= d_wdata;
                    end
                    if (grant_d && d_we && d_led_hi) begin
                        led_2 <= d_wdata[7:0];
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    i_vld_q <= 1'b0;
                    d_vld_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A reset arriving during RESP suppresses the completion pulse immediately.
    always_comb begin
        i_valid = i_vld_q && !rst;
        d_valid = d_vld_q && !rst;
        i_rdata = i_valid ? m_rdata : 16'h0000;
        d_rdata = 16'h0000;
        if (d_valid && !d_we_q) begin
            d_rdata = d_led_q ? led_rd_q : m_rdata;
        end
        led = {led_2, led_1, led_0};
    end

endmodule
